dvs_aer_rx_fifo: RTL and testbench
==================================

DVS_AER_RX_FIFO -- requirements
Module: dvs_aer_rx_fifo

Interface
REQ-001 Parameters (name, default, meaning):
  AER_WIDTH 10, AER data bus width
  X_BITS 9, event X address width
  Y_BITS 8, event Y address width
  TS_BITS 32, microsecond timestamp width
  CLKS_PER_US 10, clock cycles per microsecond, >=1
  SETUP_CYCLES 3, cycles between synced req and data sample, >=0
  TIMEOUT_CYCLES 1024, maximum cycles to wait for req release, >=1
  FIFO_DEPTH 8, event FIFO depth, power of 2, >=2
REQ-002 Legal parameters: X_BITS+1 <= AER_WIDTH and Y_BITS <= AER_WIDTH; others are illegal and are rejected at elaboration.
REQ-003 Ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset; one clock, reset is synchronous and active-low
  aer  in  AER_WIDTH  asynchronous AER data
  xsel  in  1  asynchronous; 0 = Y address, 1 = X address + polarity
  req  in  1  asynchronous sender request
  ack  out  1  receiver acknowledge
  ev_valid  out  1  FIFO head holds an event
  ev_ready  in  1  consumer accepts head
  ev_x  out  X_BITS  head X address
  ev_y  out  Y_BITS  head Y address
  ev_ts  out  TS_BITS  head timestamp, us
  ev_pol  out  1  head polarity
  fifo_level  out  clog2(FIFO_DEPTH)+1  stored event count
  drop_count  out  16  dropped X events, saturating
  timeout_err  out  1  one-cycle pulse on handshake timeout

Function
REQ-004 aer, xsel, req pass through a two-flop synchronizer; all logic uses synced copies only.
REQ-005 us timer: prescaler counts 0..CLKS_PER_US-1; us counter increments (mod 2^TS_BITS) on prescaler wrap.
REQ-006 FSM states: IDLE, SETUP, CAPTURE, ACK_HOLD, RECOVER.
REQ-007 IDLE: synced req high -> SETUP if SETUP_CYCLES>0, else CAPTURE.
REQ-008 SETUP: stays exactly SETUP_CYCLES cycles, then CAPTURE; applies to X and Y transfers alike.
REQ-009 CAPTURE: one cycle, samples synced aer/xsel, -> ACK_HOLD.
REQ-010 ACK_HOLD: synced req low -> IDLE; req high for TIMEOUT_CYCLES cycles in ACK_HOLD -> RECOVER with timeout_err pulsed 1 cycle.
REQ-011 RECOVER: ack low; synced req low -> IDLE.
REQ-012 ack is registered, high exactly in CAPTURE and ACK_HOLD.
REQ-013 Y capture (xsel=0): y_reg <= aer[Y_BITS-1:0], ts_reg <= current us counter, y_valid <= 1; no FIFO push.
REQ-014 X capture (xsel=1): event {x=aer[X_BITS:1], pol=aer[0], y=y_reg, ts=ts_reg} pushed to FIFO if y_valid and FIFO not full-after-pop.
REQ-015 X capture with y_valid=0, or FIFO full with no same-cycle pop: event discarded, drop_count +1, saturating at 16'hFFFF.
REQ-016 Entry to RECOVER clears y_valid.
REQ-017 FIFO: first-word fall-through; ev_valid = level>0; pop when ev_valid & ev_ready; push and pop in same cycle allowed at any level including full; ev_* stable while ev_valid & !ev_ready.
REQ-018 Latency: pushed event visible on ev_valid the cycle after CAPTURE when FIFO was empty.
REQ-019 ev_x/ev_y/ev_ts/ev_pol undefined-but-stable (0 after reset) when ev_valid=0.

Reset
REQ-020 rst_n low at a clk edge: FSM IDLE, synchronizer flops, prescaler, us counter, y_reg, ts_reg, y_valid, timeout counter, FIFO pointers, drop_count all 0; ack=0, ev_valid=0, fifo_level=0, timeout_err=0, ev_* = 0.
REQ-021 Reset mid-handshake aborts the transfer with no push; ack low from the first cycle after reset sampled.

Verification
REQ-022 Defaults, Y=0x2A then X aer=0x0F3 with ev_ready=1 -> one event x=0x79, pol=1, y=0x2A, ts=us at Y capture; ack low after each req release.
REQ-023 X before any Y after reset -> no ev_valid, drop_count=1, ack handshake completes normally.
REQ-024 ev_ready=0, Y then 10 X events -> fifo_level=8, drop_count=2; drain gives first 8 X in order.
REQ-025 req held high 2000 cycles after ack -> timeout_err single pulse ~1024 cycles into ACK_HOLD, ack low, next X dropped (y_valid cleared).
REQ-026 SETUP_CYCLES=0 and =5: cycles from synced req to ack rise = 1 and 6 respectively.
REQ-027 CLKS_PER_US=1, TS_BITS=4 -> timestamp wraps 15->0; reset asserted during SETUP -> no event, all outputs at reset values.

Source files
------------

// File: rtl/dvs_aer_rx_fifo.sv
// DVS AER receiver: 4-phase req/ack handshake, Y/X address pairing,
// microsecond timestamping and a first-word fall-through event FIFO.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   aer, xsel, req      asynchronous sender bus, address select, request
//   ack                 registered acknowledge (high in CAPTURE/ACK_HOLD)
//   ev_valid, ev_ready  FIFO head handshake
//   ev_x/ev_y/ev_ts/ev_pol  FIFO head event fields
//   fifo_level          stored event count
//   drop_count          saturating count of discarded X events
//   timeout_err         one-cycle pulse when req is held too long
module dvs_aer_rx_fifo #(
  parameter int AER_WIDTH      = 10,
  parameter int X_BITS         = 9,
  parameter int Y_BITS         = 8,
  parameter int TS_BITS        = 32,
  parameter int CLKS_PER_US    = 10,
  parameter int SETUP_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AER_WIDTH-1:0]          aer,
  input  logic                          xsel,
  input  logic                          req,
  output logic                          ack,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [X_BITS-1:0]             ev_x,
  output logic [Y_BITS-1:0]             ev_y,
  output logic [TS_BITS-1:0]            ev_ts,
  output logic                          ev_pol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = X_BITS + 1 + Y_BITS + TS_BITS;
  localparam int SW = $clog2(SETUP_CYCLES + 1) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PW = $clog2(CLKS_PER_US) + 1;

  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLKS_PER_US - 1);
  localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);

  if (X_BITS + 1 > AER_WIDTH || Y_BITS > AER_WIDTH) begin : g_bad_width
    $error("dvs_aer_rx_fifo: address widths exceed AER_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dvs_aer_rx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (CLKS_PER_US < 1 || TIMEOUT_CYCLES < 1 || SETUP_CYCLES < 0) begin : g_bad_timing
    $error("dvs_aer_rx_fifo: illegal timing parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CAPTURE,
    S_ACK_HOLD,
    S_RECOVER
  } state_t;

  logic [AER_WIDTH-1:0] aer_m, aer_s;
  logic                 xsel_m, xsel_s;
  logic                 req_m, req_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aer_m  <= '0;
      aer_s  <= '0;
      xsel_m <= 1'b0;
      xsel_s <= 1'b0;
      req_m  <= 1'b0;
      req_s  <= 1'b0;
    end else begin
      aer_m  <= aer;
      aer_s  <= aer_m;
      xsel_m <= xsel;
      xsel_s <= xsel_m;
      req_m  <= req;
      req_s  <= req_m;
    end
  end

  logic [PW-1:0]      presc;
  logic [TS_BITS-1:0] us_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (presc == PRE_LAST) begin
      presc  <= '0;
      us_cnt <= us_cnt + 1'b1;
    end else begin
      presc  <= presc + 1'b1;
    end
  end

  state_t             state;
  logic [SW-1:0]      setup_cnt;
  logic [TW-1:0]      to_cnt;
  logic [Y_BITS-1:0]  y_reg;
  logic [TS_BITS-1:0] ts_reg;
  logic               y_valid;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, push, cap_x, drop;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == FULL_LVL);
  assign ev_valid   = (level != '0);
  assign fifo_level = level;
  assign pop        = ev_valid & ev_ready;

  // A full FIFO still accepts an X event when the head leaves this cycle.
  assign cap_x = (state == S_CAPTURE) & xsel_s;
  assign push  = cap_x & y_valid & (~full | pop);
  assign drop  = cap_x & ~push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ack         <= 1'b0;
      timeout_err <= 1'b0;
      setup_cnt   <= '0;
      to_cnt      <= '0;
      y_reg       <= '0;
      ts_reg      <= '0;
      y_valid     <= 1'b0;
      drop_count  <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (drop && drop_count != '1)
        drop_count <= drop_count + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (req_s) begin
            if (SETUP_CYCLES == 0) begin
              state <= S_CAPTURE;
              ack   <= 1'b1;
            end else begin
              state     <= S_SETUP;
              setup_cnt <= '0;
            end
          end
        end
        S_SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state <= S_CAPTURE;
            ack   <= 1'b1;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          state  <= S_ACK_HOLD;
          to_cnt <= '0;
          if (!xsel_s) begin
            y_reg   <= aer_s[Y_BITS-1:0];
            ts_reg  <= us_cnt;
            y_valid <= 1'b1;
          end
        end
        S_ACK_HOLD: begin
          if (!req_s) begin
            state <= S_IDLE;
            ack   <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state       <= S_RECOVER;
            ack         <= 1'b0;
            timeout_err <= 1'b1;
            y_valid     <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RECOVER: begin
          if (!req_s)
            state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {aer_s[X_BITS:1], aer_s[0], y_reg, ts_reg};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head slot keeps its last contents once drained, so outputs stay stable.
  assign {ev_x, ev_pol, ev_y, ev_ts} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_dvs_aer_rx_fifo.sv
// Self-checking bench for dvs_aer_rx_fifo: queue-based reference model,
// randomized transfers, default instance plus a fast-timestamp instance.
module tb_dvs_aer_rx_fifo;

  localparam int S   = 3;
  localparam int TO  = 1024;
  localparam int CPU = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  aer = '0;
  logic        xsel = 1'b0;
  logic        req = 1'b0;
  logic        ev_ready = 1'b0;

  logic        ack, ev_valid, ev_pol, timeout_err;
  logic [8:0]  ev_x;
  logic [7:0]  ev_y;
  logic [31:0] ev_ts;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count;

  logic        ack2, ev2_valid, ev2_pol, to2;
  logic [8:0]  ev2_x;
  logic [7:0]  ev2_y;
  logic [3:0]  ev2_ts;
  logic [3:0]  ev2_level;
  logic [15:0] drop2;

  always #5 clk = ~clk;

  dvs_aer_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req),
    .ack(ack), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_ts(ev_ts), .ev_pol(ev_pol),
    .fifo_level(fifo_level), .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  dvs_aer_rx_fifo #(
    .TS_BITS(4), .CLKS_PER_US(1), .SETUP_CYCLES(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req),
    .ack(ack2), .ev_valid(ev2_valid), .ev_ready(1'b1),
    .ev_x(ev2_x), .ev_y(ev2_y), .ev_ts(ev2_ts), .ev_pol(ev2_pol),
    .fifo_level(ev2_level), .drop_count(drop2),
    .timeout_err(to2)
  );

  typedef struct packed {
    logic [8:0]  x;
    logic        pol;
    logic [7:0]  y;
    logic [31:0] ts;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          cap_edge = -1;
  int          to_edge = -1;
  logic        cap_x = 1'b0;
  logic [9:0]  cap_aer = '0;
  logic        yv = 1'b0;
  logic [7:0]  yreg = '0;
  logic [31:0] tsreg = '0;
  int          drops = 0;

  logic        yv2 = 1'b0;
  logic [7:0]  y2 = '0;
  logic [3:0]  ts2 = '0;
  int          drops2 = 0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int rdy_mode = 0;
  int to_pulses = 0;
  int to_cyc = 0;
  int to2_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: edge-indexed, event queue for the FIFO.
  initial forever begin : model
    bit   pop;
    ev_t  e;
    @(posedge clk);
    if (!rst_n) begin
      cyc = 0;
      q.delete();
      yv = 1'b0;
      yreg = '0;
      tsreg = '0;
      drops = 0;
      cap_edge = -1;
      to_edge = -1;
    end else begin
      cyc++;
      pop = ev_ready && q.size() > 0;
      if (cyc == to_edge)
        yv = 1'b0;
      if (cyc == cap_edge) begin
        if (!cap_x) begin
          yreg = cap_aer[7:0];
          tsreg = 32'((cyc - 1) / CPU);
          yv = 1'b1;
        end else if (yv && (q.size() < 8 || pop)) begin
          e.x = cap_aer[9:1];
          e.pol = cap_aer[0];
          e.y = yreg;
          e.ts = tsreg;
          q.push_back(e);
        end else if (drops < 65535) begin
          drops++;
        end
      end
      if (pop)
        void'(q.pop_front());
    end
  end

  initial forever begin : scoreboard
    @(negedge clk);
    if (chk_en) begin
      chk("valid", ev_valid, q.size() > 0);
      chk("level", fifo_level, q.size());
      chk("drops", drop_count, drops);
      if (q.size() > 0)
        chk("head", {ev_x, ev_pol, ev_y, ev_ts}, q[0]);
    end
  end

  initial forever begin : ready_drv
    @(negedge clk);
    if (rdy_mode == 2)
      ev_ready = 1'($urandom % 2);
    else
      ev_ready = (rdy_mode == 1);
  end

  initial forever begin : to_mon
    @(negedge clk);
    if (timeout_err) begin
      to_pulses++;
      to_cyc = cyc;
    end
    if (to2)
      to2_pulses++;
  end

  task automatic send(input logic x, input logic [9:0] a, input int hold);
    int n, m;
    bit seen2, big;
    big = hold > 1100;
    aer = a;
    xsel = x;
    @(negedge clk);
    req = 1'b1;
    n = cyc;
    cap_x = x;
    cap_aer = a;
    cap_edge = n + 4 + S;
    if (big)
      to_edge = n + 4 + S + TO;
    seen2 = 0;
    for (int i = 0; i < 40 && !ack; i++) begin
      @(negedge clk);
      if (ack2 && !seen2) begin
        seen2 = 1;
        chk("ack2_lat", cyc - n, 3);
      end
      if (cyc == n + 4 && x && yv2)
        chk("ev2", {ev2_valid, ev2_level, ev2_x, ev2_pol, ev2_y, ev2_ts},
            {1'b1, 4'd1, a[9:1], a[0], y2, ts2});
    end
    chk("ack_lat", cyc - n, 3 + S);
    chk("ack2_seen", seen2, 1);
    if (!x) begin
      y2 = a[7:0];
      ts2 = 4'((n + 3) % 16);
      yv2 = 1'b1;
    end else if (!yv2) begin
      drops2++;
    end
    repeat (hold) @(negedge clk);
    req = 1'b0;
    m = cyc;
    for (int i = 0; i < 40 && ack; i++)
      @(negedge clk);
    chk("ack_rel", cyc - m, big ? 0 : 3);
    if (big) begin
      yv2 = 1'b0;
      to_edge = -1;
    end
    chk("drop2", drop2, drops2);
    repeat (2) @(negedge clk);
  endtask

  task automatic summary;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin : watchdog
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin : main
    int p, p2, d0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_ack", ack, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_ev", {ev_x, ev_y, ev_ts, ev_pol}, 0);
    chk("rst_to", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(1'b1, 10'h0F3, 1);
    chk("x_no_y_drop", drop_count, 1);
    chk("x_no_y_valid", ev_valid, 0);

    send(1'b0, 10'h02A, 0);
    send(1'b1, 10'h0F3, 2);
    chk("first_ev", {ev_valid, ev_x, ev_pol, ev_y},
        {1'b1, 9'h079, 1'b1, 8'h2A});
    chk("first_ts", ev_ts, tsreg);
    rdy_mode = 1;
    repeat (4) @(negedge clk);
    chk("popped", fifo_level, 0);

    rdy_mode = 0;
    send(1'b0, 10'($urandom), 0);
    for (int i = 0; i < 10; i++)
      send(1'b1, 10'($urandom), 0);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_drop", drop_count, 3);
    rdy_mode = 1;
    repeat (12) @(negedge clk);
    chk("drained", fifo_level, 0);

    rdy_mode = 2;
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 9) < 7), 10'($urandom),
           $urandom_range(0, 4));

    rdy_mode = 1;
    while (((cyc + 4) % 16) != 15) @(negedge clk);
    send(1'b0, 10'h055, 0);
    send(1'b1, 10'h1A3, 0);
    while (((cyc + 4) % 16) != 0) @(negedge clk);
    send(1'b0, 10'h0AA, 0);
    send(1'b1, 10'h2C5, 1);

    send(1'b0, 10'h033, 0);
    p = to_pulses;
    p2 = to2_pulses;
    send(1'b1, 10'h0F1, 2000);
    chk("to_pulse", to_pulses - p, 1);
    chk("to2_pulse", to2_pulses - p2, 1);
    chk("to_cyc", to_cyc, cap_edge + TO);
    d0 = drops;
    send(1'b1, 10'h0F3, 0);
    chk("to_drop", drop_count, d0 + 1);

    rdy_mode = 0;
    repeat (3) @(negedge clk);
    send(1'b0, 10'($urandom), 0);
    send(1'b1, 10'($urandom), 0);
    send(1'b1, 10'($urandom), 0);
    chk("pre_rst_lvl", fifo_level, 2);
    aer = 10'h3FF;
    xsel = 1'b1;
    @(negedge clk);
    req = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_ack2", ack2, 0);
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_ev", {ev_x, ev_y, ev_ts, ev_pol}, 0);
    chk("mid_rst_ev2", ev2_valid, 0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    yv2 = 1'b0;
    drops2 = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_valid", ev_valid, 0);
    rdy_mode = 1;
    send(1'b0, 10'h011, 0);
    send(1'b1, 10'h1FF, 0);
    repeat (5) @(negedge clk);

    summary();
    $finish;
  end

endmodule
